// File: rtl/color_permute_pkg.sv
// Shared types and helpers for the colour-permutation pipeline: permutation
// index encoding, switch modes and the per-bit channel mux.
package color_permute_pkg;

  localparam int unsigned PERM_W = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned SW_W   = 10;

  typedef logic [PERM_W-1:0] perm_t;

  typedef enum logic [MODE_W-1:0] {
    BYPASS  = 2'b00,
    DIRECT  = 2'b01,
    CASCADE = 2'b10,
    AUTO    = 2'b11
  } mode_t;

  localparam perm_t PERM_IDENTITY = 3'd0;
  localparam perm_t PERM_LAST     = 3'd5;

  // One bit-slice of an RGB pixel, named by output slot.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_bit_t;

  // Net effect of the ordered swaps R<->B (sel[0]), G<->B (sel[1]), R<->G (sel[2]).
  function automatic perm_t cascade_to_perm(input logic [SEL_W-1:0] sel);
    perm_t p;
    p = PERM_IDENTITY;
    case (sel)
      3'b000:  p = 3'd0;
      3'b001:  p = 3'd2;
      3'b010:  p = 3'd1;
      3'b011:  p = 3'd3;
      3'b100:  p = 3'd5;
      3'b101:  p = 3'd4;
      3'b110:  p = 3'd3;
      3'b111:  p = 3'd1;
      default: p = PERM_IDENTITY;
    endcase
    return p;
  endfunction

  // Direct selection; out-of-range codes fall back to identity.
  function automatic perm_t direct_to_perm(input logic [SEL_W-1:0] sel);
    perm_t p;
    p = PERM_IDENTITY;
    if (sel <= PERM_LAST) begin
      p = perm_t'(sel);
    end
    return p;
  endfunction

  // Single-bit channel routing; callers iterate over their own channel width.
  function automatic rgb_bit_t perm_mux(input perm_t p, input logic r,
                                        input logic g, input logic b);
    rgb_bit_t o;
    o.r = r;
    o.g = g;
    o.b = b;
    case (p)
      3'd1: begin o.r = r; o.g = b; o.b = g; end
      3'd2: begin o.r = b; o.g = g; o.b = r; end
      3'd3: begin o.r = b; o.g = r; o.b = g; end
      3'd4: begin o.r = g; o.g = b; o.b = r; end
      3'd5: begin o.r = g; o.g = r; o.b = b; end
      default: begin o.r = r; o.g = g; o.b = b; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/color_permute_pipe_cfg.sv
// Frame-synchronous configuration: detects the frame-start edge, latches mode
// and permutation, and runs the auto-cycle frame counter.
module perm_cfg_ctrl
  import color_permute_pkg::*;
#(
  parameter int unsigned CYCLE_FRAMES = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_sel_i,
  input  logic [2:0]  perm_sel_i,
  input  logic        vs_i,
  output logic [2:0]  perm_o,
  output logic [1:0]  mode_o
);

  localparam int unsigned FC_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(CYCLE_FRAMES - 1);

  logic            vs_q;
  mode_t           mode_q, mode_d;
  perm_t           perm_q, perm_d;
  perm_t           ai_q, ai_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic            fs_c;
  mode_t           sw_mode_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q   <= 1'b0;
      mode_q <= BYPASS;
      perm_q <= PERM_IDENTITY;
      ai_q   <= PERM_IDENTITY;
      fc_q   <= '0;
    end else begin
      vs_q   <= vs_i;
      mode_q <= mode_d;
      perm_q <= perm_d;
      ai_q   <= ai_d;
      fc_q   <= fc_d;
    end
  end

  // Config only moves on a frame-start edge; fc/ai restart whenever auto is (re)entered or left.
  always_comb begin
    fs_c      = vs_i & ~vs_q;
    sw_mode_c = mode_t'(mode_sel_i);
    mode_d    = mode_q;
    perm_d    = perm_q;
    ai_d      = ai_q;
    fc_d      = fc_q;
    if (fs_c) begin
      mode_d = sw_mode_c;
      ai_d   = PERM_IDENTITY;
      fc_d   = '0;
      case (sw_mode_c)
        BYPASS:  perm_d = PERM_IDENTITY;
        DIRECT:  perm_d = direct_to_perm(perm_sel_i);
        CASCADE: perm_d = cascade_to_perm(perm_sel_i);
        AUTO: begin
          if (mode_q == AUTO) begin
            if (fc_q == FC_LAST) begin
              fc_d = '0;
              ai_d = (ai_q == PERM_LAST) ? PERM_IDENTITY : ai_q + PERM_W'(1);
            end else begin
              fc_d = fc_q + FC_W'(1);
              ai_d = ai_q;
            end
          end
          perm_d = ai_d;
        end
        default: perm_d = PERM_IDENTITY;
      endcase
    end
  end

  assign perm_o = perm_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/color_permute_pipe.sv
// Two-stage RGB channel permutation pipeline; the permutation index rides with
// each pixel so in-flight pixels are never affected by a config change.
module color_permute_pipe
  import color_permute_pkg::*;
#(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned CYCLE_FRAMES = 30
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [9:0]        iSW,
  input  logic              iVS,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic [2:0]        oPerm
);

  logic [2:0]        cfg_perm;
  logic [1:0]        cfg_mode;
  logic              sw_unused;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_red_q, s1_green_q, s1_blue_q;
  perm_t             s1_perm_q, s1_perm_d;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_red_q, s2_green_q, s2_blue_q;
  logic [DATA_W-1:0] s2_red_d, s2_green_d, s2_blue_d;
  rgb_bit_t          px_bit;

  assign sw_unused = ^iSW[7:3];

  perm_cfg_ctrl #(
    .CYCLE_FRAMES(CYCLE_FRAMES)
  ) u_cfg (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .mode_sel_i (iSW[9:8]),
    .perm_sel_i (iSW[2:0]),
    .vs_i       (iVS),
    .perm_o     (cfg_perm),
    .mode_o     (cfg_mode)
  );

  assign s1_perm_d = (mode_t'(cfg_mode) == BYPASS) ? PERM_IDENTITY : perm_t'(cfg_perm);

  // Stage 1: capture pixel together with the permutation in force this cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_valid_q <= 1'b0;
      s1_red_q   <= '0;
      s1_green_q <= '0;
      s1_blue_q  <= '0;
      s1_perm_q  <= PERM_IDENTITY;
    end else begin
      s1_valid_q <= iDVAL;
      s1_red_q   <= iRed;
      s1_green_q <= iGreen;
      s1_blue_q  <= iBlue;
      s1_perm_q  <= s1_perm_d;
    end
  end

  always_comb begin
    s2_red_d   = '0;
    s2_green_d = '0;
    s2_blue_d  = '0;
    px_bit     = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      px_bit        = perm_mux(s1_perm_q, s1_red_q[i], s1_green_q[i], s1_blue_q[i]);
      s2_red_d[i]   = px_bit.r;
      s2_green_d[i] = px_bit.g;
      s2_blue_d[i]  = px_bit.b;
    end
  end

  // Stage 2: registered permuted output.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s2_valid_q <= 1'b0;
      s2_red_q   <= '0;
      s2_green_q <= '0;
      s2_blue_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_red_q   <= s2_red_d;
      s2_green_q <= s2_green_d;
      s2_blue_q  <= s2_blue_d;
    end
  end

  assign oDVAL  = s2_valid_q;
  assign oRed   = s2_red_q;
  assign oGreen = s2_green_q;
  assign oBlue  = s2_blue_q;
  assign oPerm  = cfg_perm;

endmodule

// File: tb/tb_color_permute_pipe.sv
// Directed bench for color_permute_pipe: a vector table over all modes plus
// hand-written sequences for frame-edge, reset and auto-cycle corners.
module tb_color_permute_pipe;

  localparam int unsigned DW = 10;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [9:0]    iSW;
  logic          iVS;
  logic          iDVAL;
  logic [DW-1:0] iRed, iGreen, iBlue;
  logic          oDVAL;
  logic [DW-1:0] oRed, oGreen, oBlue;
  logic [2:0]    oPerm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0]  sw;
    logic [29:0] pix;
    logic [29:0] exp;
    logic [2:0]  perm;
  } vec_t;

  vec_t vecs[$];
  int   exp_auto[14] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0};

  color_permute_pipe #(
    .DATA_W      (DW),
    .CYCLE_FRAMES(2)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iSW   (iSW),
    .iVS   (iVS),
    .iDVAL (iDVAL),
    .iRed  (iRed),
    .iGreen(iGreen),
    .iBlue (iBlue),
    .oDVAL (oDVAL),
    .oRed  (oRed),
    .oGreen(oGreen),
    .oBlue (oBlue),
    .oPerm (oPerm)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [29:0] rgb(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic vec_t mk(input logic [9:0] sw, input logic [29:0] pix,
                              input logic [29:0] exp, input logic [2:0] perm);
    vec_t v;
    v.sw   = sw;
    v.pix  = pix;
    v.exp  = exp;
    v.perm = perm;
    return v;
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_pix(input logic [29:0] p, input logic v);
    {iRed, iGreen, iBlue} = p;
    iDVAL = v;
  endtask

  task automatic frame_edge();
    iVS = 1'b1;
    step();
    iVS = 1'b0;
    step();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    iSW = v.sw;
    frame_edge();
    set_pix(v.pix, 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    step();
    chk($sformatf("vec%0d_dval", idx), 32'(oDVAL), 32'd1);
    chk($sformatf("vec%0d_rgb", idx), 32'({oRed, oGreen, oBlue}), 32'(v.exp));
    chk($sformatf("vec%0d_perm", idx), 32'(oPerm), 32'(v.perm));
    step();
    chk($sformatf("vec%0d_dval_drop", idx), 32'(oDVAL), 32'd0);
  endtask

  initial begin
    iRST = 1'b1;
    iVS  = 1'b0;
    iSW  = '0;
    set_pix(30'h0, 1'b0);

    vecs.push_back(mk(10'h000, rgb(1, 2, 3), rgb(1, 2, 3), 3'd0));
    vecs.push_back(mk(10'h0F8, rgb(1, 2, 3), rgb(1, 2, 3), 3'd0));
    vecs.push_back(mk(10'h101, rgb(1, 2, 3), rgb(1, 3, 2), 3'd1));
    vecs.push_back(mk(10'h102, rgb(1, 2, 3), rgb(3, 2, 1), 3'd2));
    vecs.push_back(mk(10'h103, rgb(1, 2, 3), rgb(3, 1, 2), 3'd3));
    vecs.push_back(mk(10'h104, rgb(1, 2, 3), rgb(2, 3, 1), 3'd4));
    vecs.push_back(mk(10'h105, rgb(1, 2, 3), rgb(2, 1, 3), 3'd5));
    vecs.push_back(mk(10'h106, rgb(1, 2, 3), rgb(1, 2, 3), 3'd0));
    vecs.push_back(mk(10'h107, rgb(1, 2, 3), rgb(1, 2, 3), 3'd0));
    vecs.push_back(mk(10'h1FB, rgb(1, 2, 3), rgb(3, 1, 2), 3'd3));
    vecs.push_back(mk(10'h200, rgb(10'h3FF, 0, 10'h2AA), rgb(10'h3FF, 0, 10'h2AA), 3'd0));
    vecs.push_back(mk(10'h201, rgb(10'h3FF, 0, 10'h2AA), rgb(10'h2AA, 0, 10'h3FF), 3'd2));
    vecs.push_back(mk(10'h202, rgb(10'h3FF, 0, 10'h2AA), rgb(10'h3FF, 10'h2AA, 0), 3'd1));
    vecs.push_back(mk(10'h203, rgb(1, 2, 3), rgb(3, 1, 2), 3'd3));
    vecs.push_back(mk(10'h204, rgb(10'h3FF, 0, 10'h2AA), rgb(0, 10'h3FF, 10'h2AA), 3'd5));
    vecs.push_back(mk(10'h205, rgb(10'h3FF, 0, 10'h2AA), rgb(0, 10'h2AA, 10'h3FF), 3'd4));
    vecs.push_back(mk(10'h206, rgb(1, 2, 3), rgb(3, 1, 2), 3'd3));
    vecs.push_back(mk(10'h207, rgb(1, 2, 3), rgb(1, 3, 2), 3'd1));

    step();
    step();
    chk("rst_dval", 32'(oDVAL), 32'd0);
    chk("rst_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
    chk("rst_perm", 32'(oPerm), 32'd0);

    // Switches set but no frame edge yet: still bypass.
    iRST = 1'b0;
    iSW  = 10'h103;
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    step();
    chk("prefs_dval", 32'(oDVAL), 32'd1);
    chk("prefs_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(1, 2, 3)));
    chk("prefs_perm", 32'(oPerm), 32'd0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Mid-frame select change is ignored until the next frame edge.
    iSW = 10'h103;
    frame_edge();
    iSW = 10'h104;
    step();
    step();
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    step();
    chk("mid_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(3, 1, 2)));
    chk("mid_perm", 32'(oPerm), 32'd3);
    frame_edge();
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    step();
    chk("next_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(2, 3, 1)));
    chk("next_perm", 32'(oPerm), 32'd4);

    // iVS held high: only the first cycle is a frame edge.
    iSW = 10'h101;
    iVS = 1'b1;
    step();
    chk("held_first", 32'(oPerm), 32'd1);
    iSW = 10'h102;
    repeat (5) step();
    chk("held_long", 32'(oPerm), 32'd1);
    iVS = 1'b0;
    step();
    chk("held_fall", 32'(oPerm), 32'd1);
    frame_edge();
    chk("held_next", 32'(oPerm), 32'd2);

    // Frame edge on the same cycle a pixel is sampled.
    iSW = 10'h103;
    iVS = 1'b1;
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    iVS = 1'b0;
    set_pix(rgb(4, 5, 6), 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    chk("bnd_old_dval", 32'(oDVAL), 32'd1);
    chk("bnd_old_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(3, 2, 1)));
    step();
    chk("bnd_new_dval", 32'(oDVAL), 32'd1);
    chk("bnd_new_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(6, 4, 5)));
    step();
    chk("bnd_drop", 32'(oDVAL), 32'd0);

    // One-cycle reset mid-stream, coincident with a VS rise.
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    iRST = 1'b1;
    iVS  = 1'b1;
    set_pix(rgb(4, 5, 6), 1'b1);
    step();
    chk("mrst0_dval", 32'(oDVAL), 32'd0);
    chk("mrst0_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
    chk("mrst0_perm", 32'(oPerm), 32'd0);
    iRST = 1'b0;
    iVS  = 1'b0;
    set_pix(rgb(7, 8, 9), 1'b1);
    step();
    chk("mrst1_dval", 32'(oDVAL), 32'd0);
    chk("mrst1_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
    set_pix(30'h0, 1'b0);
    step();
    chk("mrst2_dval", 32'(oDVAL), 32'd1);
    chk("mrst2_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(7, 8, 9)));
    chk("mrst2_perm", 32'(oPerm), 32'd0);
    frame_edge();
    chk("mrst_fs_perm", 32'(oPerm), 32'd3);

    // Auto cycling with two frames per step.
    iSW = 10'h300;
    for (int i = 0; i < 14; i++) begin
      iVS = 1'b1;
      step();
      chk($sformatf("auto%0d", i), 32'(oPerm), 32'(exp_auto[i]));
      iVS = 1'b0;
      step();
    end

    // Leave auto, then re-enter: counter restarts from zero.
    iSW = 10'h102;
    frame_edge();
    chk("leave_perm", 32'(oPerm), 32'd2);
    iSW = 10'h300;
    frame_edge();
    chk("reenter0", 32'(oPerm), 32'd0);
    frame_edge();
    chk("reenter1", 32'(oPerm), 32'd0);
    frame_edge();
    chk("reenter2", 32'(oPerm), 32'd1);
    set_pix(rgb(1, 2, 3), 1'b1);
    step();
    set_pix(30'h0, 1'b0);
    step();
    chk("auto_rgb", 32'({oRed, oGreen, oBlue}), 32'(rgb(1, 3, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
